// File: rtl/ifetch_thread_select_pkg.sv
// rtl/ifetch_thread_select_pkg.sv - shared types and constants for the ifetch thread select stage
//
// Purpose: thread index/bitmap types, the PC scalar type and the instruction
// size used to step a thread's fetch PC.
// Ports: none (package).

package ifetch_thread_select_pkg;

  localparam int THREADS_PER_CORE = 4;
  localparam int THREAD_IDX_WIDTH = $clog2(THREADS_PER_CORE);

  typedef logic [THREAD_IDX_WIDTH-1:0] local_thread_idx_t;
  typedef logic [THREADS_PER_CORE-1:0] local_thread_bitmap_t;
  typedef logic [31:0]                 scalar_t;

  localparam scalar_t INSTRUCTION_SIZE = 32'd4;

endpackage

// File: rtl/ifetch_thread_select_arb.sv
// rtl/ifetch_thread_select_arb.sv - round-robin arbiter and one-hot to index encoder
//
// Purpose: rr_arbiter grants one requester per cycle, starting its search at
// the priority pointer; the pointer moves to the requester after the winner.
// oh_to_idx converts a one-hot (or zero) vector to a binary index.
// rr_arbiter ports:
//   clk, reset     - clock, synchronous active-high reset (pointer -> 0)
//   request        - per-requester request vector
//   update_lru     - allow the pointer to advance when a grant is made
//   grant_oh       - combinational one-hot grant (zero when no request)
// oh_to_idx ports:
//   one_hot        - one-hot or zero input vector
//   index          - binary index of the set bit (0 when input is zero)

module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             found;

  // Search from the pointer upward; index arithmetic wraps because the
  // requester count is a power of two.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && request[cand]) begin
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
        found          = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && update_lru) begin
      ptr_d = grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

module oh_to_idx #(
  parameter int NUM_SIGNALS = 4
) (
  input  logic [NUM_SIGNALS-1:0]         one_hot,
  output logic [$clog2(NUM_SIGNALS)-1:0] index
);

  localparam int IDX_W = $clog2(NUM_SIGNALS);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      if (one_hot[i]) begin
        index = index | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ifetch_thread_select.sv
// rtl/ifetch_thread_select.sv - per-thread fetch PC tracking and round-robin fetch selection
//
// Purpose: holds one fetch PC per hardware thread, picks one eligible thread
// per cycle and registers its PC toward the ifetch tag lookup. Applies
// writeback rollbacks and parks threads on icache misses until the L2 wake.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   ts_fetch_en                 - per-thread fetch permission from thread select
//   wb_rollback_en/_thread_idx/_pc - redirect a thread to a new PC
//   ifd_cache_miss/_thread_idx/_pc - icache miss on last cycle's fetch; refetch PC
//   l2i_icache_wake_bitmap      - threads whose missing line has been filled
//   ift_fetch_valid             - registered: a fetch was issued
//   ift_thread_idx              - registered: fetched thread (holds when idle)
//   ift_pc                      - registered: fetch address (holds when idle)
//   ift_blocked_bitmap          - registered: threads suspended on a miss

module ifetch_thread_select
  import ifetch_thread_select_pkg::*;
#(
  parameter int      NUM_THREADS = THREADS_PER_CORE,
  parameter scalar_t RESET_PC    = 32'h0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         ts_fetch_en,
  input  logic                           wb_rollback_en,
  input  logic [$clog2(NUM_THREADS)-1:0] wb_rollback_thread_idx,
  input  scalar_t                        wb_rollback_pc,
  input  logic                           ifd_cache_miss,
  input  logic [$clog2(NUM_THREADS)-1:0] ifd_cache_miss_thread_idx,
  input  scalar_t                        ifd_cache_miss_pc,
  input  logic [NUM_THREADS-1:0]         l2i_icache_wake_bitmap,
  output logic                           ift_fetch_valid,
  output logic [$clog2(NUM_THREADS)-1:0] ift_thread_idx,
  output scalar_t                        ift_pc,
  output logic [NUM_THREADS-1:0]         ift_blocked_bitmap
);

  localparam int IDX_W = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0] rollback_oh;
  logic [NUM_THREADS-1:0] miss_oh;
  logic [NUM_THREADS-1:0] request;
  logic [NUM_THREADS-1:0] grant_oh;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;

  logic [NUM_THREADS-1:0] blocked_q;
  logic [NUM_THREADS-1:0] blocked_d;
  scalar_t                next_pc_q [NUM_THREADS];
  scalar_t                next_pc_d [NUM_THREADS];

  logic                   fetch_valid_q;
  logic [IDX_W-1:0]       thread_idx_q;
  scalar_t                pc_q;

  always_comb begin
    rollback_oh = '0;
    miss_oh     = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      rollback_oh[t] = wb_rollback_en && (wb_rollback_thread_idx == IDX_W'(t));
      miss_oh[t]     = ifd_cache_miss && (ifd_cache_miss_thread_idx == IDX_W'(t));
    end
  end

  // A thread being redirected or reporting a miss has a stale next_pc this
  // cycle, so it sits out arbitration until the new PC is in place.
  assign request   = ts_fetch_en & ~blocked_q & ~rollback_oh & ~miss_oh;
  assign grant_any = |grant_oh;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_THREADS)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .update_lru(1'b1),
    .grant_oh  (grant_oh)
  );

  oh_to_idx #(
    .NUM_SIGNALS(NUM_THREADS)
  ) u_oh_to_idx (
    .one_hot(grant_oh),
    .index  (grant_idx)
  );

  // Rollback beats miss beats sequential advance.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      next_pc_d[t] = next_pc_q[t];
      if (rollback_oh[t]) begin
        next_pc_d[t] = wb_rollback_pc;
      end else if (miss_oh[t]) begin
        next_pc_d[t] = ifd_cache_miss_pc;
      end else if (grant_oh[t]) begin
        next_pc_d[t] = next_pc_q[t] + INSTRUCTION_SIZE;
      end
    end
  end

  // A wake in the same cycle as the miss means the line is already filled,
  // so the wake mask is applied after the new miss bit is merged in.
  assign blocked_d = (blocked_q | miss_oh) & ~l2i_icache_wake_bitmap;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        next_pc_q[t] <= RESET_PC;
      end
      blocked_q     <= '0;
      fetch_valid_q <= 1'b0;
      thread_idx_q  <= '0;
      pc_q          <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        next_pc_q[t] <= next_pc_d[t];
      end
      blocked_q     <= blocked_d;
      fetch_valid_q <= grant_any;
      if (grant_any) begin
        thread_idx_q <= grant_idx;
        pc_q         <= next_pc_q[grant_idx];
      end
    end
  end

  assign ift_fetch_valid    = fetch_valid_q;
  assign ift_thread_idx     = thread_idx_q;
  assign ift_pc             = pc_q;
  assign ift_blocked_bitmap = blocked_q;

  a_miss_on_blocked : assert property (@(posedge clk) disable iff (reset)
    !(ifd_cache_miss && blocked_q[ifd_cache_miss_thread_idx]))
    else $error("icache miss reported on a thread that is already blocked");

  a_spurious_wake : assert property (@(posedge clk) disable iff (reset)
    ((l2i_icache_wake_bitmap & ~(blocked_q | miss_oh)) == '0))
    else $error("wake for a thread that is neither blocked nor missing");

  a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant_oh))
    else $error("fetch grant is not one-hot");

endmodule

// File: tb/tb_ifetch_thread_select.sv
// tb/tb_ifetch_thread_select.sv - self-checking bench for ifetch_thread_select

module tb_ifetch_thread_select;

  logic        clk;
  logic        reset;
  logic [3:0]  ts_fetch_en;
  logic        wb_rollback_en;
  logic [1:0]  wb_rollback_thread_idx;
  logic [31:0] wb_rollback_pc;
  logic        ifd_cache_miss;
  logic [1:0]  ifd_cache_miss_thread_idx;
  logic [31:0] ifd_cache_miss_pc;
  logic [3:0]  l2i_icache_wake_bitmap;
  logic        ift_fetch_valid;
  logic [1:0]  ift_thread_idx;
  logic [31:0] ift_pc;
  logic [3:0]  ift_blocked_bitmap;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc [4];
  logic [3:0]  m_blk;
  int          m_ptr;
  logic        m_valid;
  logic [1:0]  m_idx;
  logic [31:0] m_opc;

  ifetch_thread_select #(
    .NUM_THREADS(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .ts_fetch_en              (ts_fetch_en),
    .wb_rollback_en           (wb_rollback_en),
    .wb_rollback_thread_idx   (wb_rollback_thread_idx),
    .wb_rollback_pc           (wb_rollback_pc),
    .ifd_cache_miss           (ifd_cache_miss),
    .ifd_cache_miss_thread_idx(ifd_cache_miss_thread_idx),
    .ifd_cache_miss_pc        (ifd_cache_miss_pc),
    .l2i_icache_wake_bitmap   (l2i_icache_wake_bitmap),
    .ift_fetch_valid          (ift_fetch_valid),
    .ift_thread_idx           (ift_thread_idx),
    .ift_pc                   (ift_pc),
    .ift_blocked_bitmap       (ift_blocked_bitmap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"},   32'(ift_fetch_valid),    32'(m_valid));
    chk({tag, "_idx"},     32'(ift_thread_idx),     32'(m_idx));
    chk({tag, "_pc"},      ift_pc,                  m_opc);
    chk({tag, "_blocked"}, 32'(ift_blocked_bitmap), 32'(m_blk));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ts_fetch_en = 4'b0; wb_rollback_en = 1'b0; ifd_cache_miss = 1'b0;
    l2i_icache_wake_bitmap = 4'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int t = 0; t < 4; t++) m_pc[t] = 32'h0;
    m_blk = 4'b0; m_ptr = 0; m_valid = 1'b0; m_idx = 2'd0; m_opc = 32'h0;
    check_outputs(tag);
  endtask

  // One clock cycle: drive inputs, advance the model by the stage rules,
  // then compare registered outputs one time unit after the edge.
  task automatic step(input string tag, input logic [3:0] en,
                      input logic rb, input logic [1:0] rbi, input logic [31:0] rbpc,
                      input logic ms, input logic [1:0] msi, input logic [31:0] mspc,
                      input logic [3:0] wk);
    logic [3:0] req;
    int g;
    ts_fetch_en = en;
    wb_rollback_en = rb; wb_rollback_thread_idx = rbi; wb_rollback_pc = rbpc;
    ifd_cache_miss = ms; ifd_cache_miss_thread_idx = msi; ifd_cache_miss_pc = mspc;
    l2i_icache_wake_bitmap = wk;
    for (int t = 0; t < 4; t++)
      req[t] = en[t] && !m_blk[t] && !(rb && rbi == 2'(t)) && !(ms && msi == 2'(t));
    g = -1;
    for (int i = 0; i < 4; i++) begin
      int t;
      t = (m_ptr + i) % 4;
      if (g < 0 && req[t]) g = t;
    end
    m_valid = (g >= 0);
    if (g >= 0) begin
      m_idx = 2'(g);
      m_opc = m_pc[g];
      m_ptr = (g + 1) % 4;
    end
    for (int t = 0; t < 4; t++) begin
      if (rb && rbi == 2'(t))      m_pc[t] = rbpc;
      else if (ms && msi == 2'(t)) m_pc[t] = mspc;
      else if (t == g)             m_pc[t] = m_pc[t] + 32'd4;
    end
    if (ms) m_blk[msi] = 1'b1;
    m_blk = m_blk & ~wk;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic step_en(input string tag, input logic [3:0] en);
    step(tag, en, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0, 4'b0);
  endtask

  initial begin
    reset = 1'b1;
    ts_fetch_en = 4'b0; wb_rollback_en = 1'b0; wb_rollback_thread_idx = 2'd0;
    wb_rollback_pc = 32'h0; ifd_cache_miss = 1'b0; ifd_cache_miss_thread_idx = 2'd0;
    ifd_cache_miss_pc = 32'h0; l2i_icache_wake_bitmap = 4'b0;
    @(posedge clk); #1;
    do_reset("reset");

    // 1: all threads enabled rotate 0,1,2,3,0 with PCs 0,0,0,0,4
    for (int k = 0; k < 5; k++) begin
      step_en("rr", 4'b1111);
      chk("rr_idx_const", 32'(ift_thread_idx), 32'(k % 4));
      chk("rr_pc_const", ift_pc, (k == 4) ? 32'h4 : 32'h0);
    end

    // 2: single thread streams, then idle holds idx/pc and the pointer
    do_reset("reset2");
    for (int k = 0; k < 3; k++) begin
      step_en("t2only", 4'b0100);
      chk("t2_pc_const", ift_pc, 32'(4 * k));
    end
    step_en("idle", 4'b0000);
    chk("idle_valid_const", 32'(ift_fetch_valid), 32'h0);
    chk("idle_pc_hold", ift_pc, 32'h8);
    step_en("ptr_held", 4'b1111);
    chk("ptr_held_idx", 32'(ift_thread_idx), 32'd3);

    // 3: miss on thread 1 blocks it until the wake, then refetch 0x104
    step("t1_rb", 4'b0000, 1'b1, 2'd1, 32'h108, 1'b0, 2'd0, 32'h0, 4'b0);
    step("t1_miss", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 32'h104, 4'b0);
    chk("t1_miss_nogrant", 32'(ift_fetch_valid), 32'h0);
    chk("t1_blocked", 32'(ift_blocked_bitmap), 32'b0010);
    step_en("t1_wait", 4'b0010);
    step("t1_wake", 4'b0010, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0, 4'b0010);
    step_en("t1_refetch", 4'b0010);
    chk("t1_refetch_pc", ift_pc, 32'h104);

    // 4: miss and wake together leave thread 3 unblocked
    step("t3_misswake", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1, 2'd3, 32'h300, 4'b1000);
    chk("t3_not_blocked", 32'(ift_blocked_bitmap), 32'h0);
    step_en("t3_fetch", 4'b1000);
    chk("t3_fetch_pc", ift_pc, 32'h300);

    // 5: rollback suppresses the grant; rollback+miss keeps rollback PC and blocks
    step("t0_rb", 4'b0001, 1'b1, 2'd0, 32'h2000, 1'b0, 2'd0, 32'h0, 4'b0);
    chk("t0_rb_nogrant", 32'(ift_fetch_valid), 32'h0);
    step_en("t0_fetch", 4'b0001);
    chk("t0_fetch_pc", ift_pc, 32'h2000);
    step("t0_rbmiss", 4'b0001, 1'b1, 2'd0, 32'h3000, 1'b1, 2'd0, 32'h3333, 4'b0);
    chk("t0_rbmiss_blk", 32'(ift_blocked_bitmap), 32'b0001);
    step("t0_wake", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0, 4'b0001);
    step_en("t0_refetch", 4'b0001);
    chk("t0_refetch_pc", ift_pc, 32'h3000);

    // 6: PC wrap, then reset mid-run with a blocked thread
    step("t2_rbtop", 4'b0000, 1'b1, 2'd2, 32'hFFFFFFFC, 1'b0, 2'd0, 32'h0, 4'b0);
    step_en("wrap0", 4'b0100);
    chk("wrap0_pc", ift_pc, 32'hFFFFFFFC);
    step_en("wrap1", 4'b0100);
    chk("wrap1_pc", ift_pc, 32'h0);
    step("t1_miss2", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 32'h55, 4'b0);
    chk("pre_reset_blk", 32'(ift_blocked_bitmap), 32'b0010);
    do_reset("midreset");
    chk("midreset_blk_const", 32'(ift_blocked_bitmap), 32'h0);
    step_en("post_reset", 4'b0010);
    chk("post_reset_pc", ift_pc, 32'h0);

    // Random traffic against the model
    do_reset("reset_rand");
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  en;
      logic        rb, ms;
      logic [1:0]  rbi, msi;
      logic [31:0] rbpc, mspc;
      logic [3:0]  moh, wk;
      en   = 4'($urandom);
      rb   = ($urandom_range(0, 7) == 0);
      rbi  = 2'($urandom);
      rbpc = $urandom;
      msi  = 2'($urandom);
      ms   = ($urandom_range(0, 5) == 0) && !m_blk[msi];
      mspc = $urandom;
      moh  = ms ? (4'b0001 << msi) : 4'b0;
      wk   = 4'($urandom) & (m_blk | moh) & (($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
      step("rand", en, rb, rbi, rbpc, ms, msi, mspc, wk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_thread_select.md
Name: ifetch_thread_select

Overview:
- Front end of the instruction pipeline. Holds one fetch PC per hardware thread.
- Each cycle, picks one thread to fetch by round robin, and presents its PC to the ifetch tag lookup.
- Consumes the per-thread fetch-enable bitmap that the thread select stage drives from its instruction FIFO occupancy.
- Applies writeback rollbacks, and suspends threads on icache misses until the L2 wake arrives.

Parameters:
- NUM_THREADS, 4, hardware threads per core; power of two, at least 2.
- RESET_PC, 32'h0, PC loaded into every thread on reset.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- ts_fetch_en  in  NUM_THREADS  per-thread fetch permission from the thread select stage (FIFO not almost full and thread enabled).
- wb_rollback_en  in  1  redirect request.
- wb_rollback_thread_idx  in  $clog2(NUM_THREADS)  thread being redirected.
- wb_rollback_pc  in  32  redirect target.
- ifd_cache_miss  in  1  icache miss on the fetch issued in the previous cycle.
- ifd_cache_miss_thread_idx  in  $clog2(NUM_THREADS)  thread that missed.
- ifd_cache_miss_pc  in  32  PC that missed; the refetch address.
- l2i_icache_wake_bitmap  in  NUM_THREADS  threads whose miss line is now filled.
- ift_fetch_valid  out  1  registered; a fetch is issued.
- ift_thread_idx  out  $clog2(NUM_THREADS)  registered; thread being fetched.
- ift_pc  out  32  registered; fetch address.
- ift_blocked_bitmap  out  NUM_THREADS  registered; threads suspended on an icache miss (performance counters, visualizer).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset values:
  - all next_pc = RESET_PC; blocked = 0; round-robin pointer = thread 0 highest priority.
  - ift_fetch_valid = 0, ift_thread_idx = 0, ift_pc = 0, ift_blocked_bitmap = 0.
- Request per thread t: request[t] = ts_fetch_en[t] && !blocked[t] && !(wb_rollback_en && idx==t) && !(ifd_cache_miss && idx==t).
  - A thread being redirected or reporting a miss this cycle is never granted in that cycle.
- Arbitration:
  - Round robin over request, combinational one-hot grant.
  - The priority pointer advances to the thread after the grant only when a grant occurs; otherwise it holds.
  - No requests: ift_fetch_valid = 0 next cycle, and ift_thread_idx / ift_pc hold their previous values.
- Latency: a grant in cycle N gives ift_fetch_valid = 1 with ift_pc = old next_pc[t] after edge N. One cycle, registered.
- PC update per thread, in priority order:
  1. rollback: next_pc = wb_rollback_pc.
  2. else miss: next_pc = ifd_cache_miss_pc.
  3. else granted: next_pc = next_pc + 4. 32-bit wrap: 32'hFFFFFFFC becomes 32'h0. Bits [1:0] are carried unmodified.
- Rollback and miss on the same thread in the same cycle: the rollback PC wins, and the blocked bit is still set.
- Blocked bitmap: blocked_next = (blocked | miss_oh) & ~l2i_icache_wake_bitmap.
  - Wake in the same cycle as a miss leaves the thread unblocked; the line was just filled.
  - Rollback does not clear blocked.
- ts_fetch_en deasserting stops new grants only; a fetch already registered on the outputs is not retracted.
- Assertions, simulation only:
  - miss on a thread already blocked;
  - wake of a thread neither blocked nor missing this cycle;
  - grant not one-hot-or-zero.
- Reset mid-operation: all state returns to reset values next edge, regardless of pending misses or rollbacks.

Decomposition:
- Shared defines package:
  - thread index and bitmap typedefs (local_thread_idx_t, local_thread_bitmap_t);
  - scalar_t for the 32-bit PC;
  - the instruction-size constant 4.
- Sub-module: reuse the existing rr_arbiter (NUM_REQUESTERS = NUM_THREADS, update_lru tied high) and oh_to_idx.
- The PC array, blocked bitmap and output registers stay in this module.

Test Plan:
1. Reset, then all ts_fetch_en = 4'b1111, no misses → grants rotate 0,1,2,3,0; ift_pc sequence 0,0,0,0,4; each thread advances by 4 per grant.
2. ts_fetch_en = 4'b0100 only → thread 2 every cycle, ift_pc 0,4,8,...; drop to 0 → ift_fetch_valid = 0 next cycle, pointer held.
3. Thread 1 at next_pc 0x108 reports miss with pc 0x104 → thread 1 not granted that cycle; blocked[1] = 1; next_pc[1] = 0x104. Wake bit 1 → thread 1 next fetches 0x104.
4. Miss and wake for thread 3 in the same cycle → blocked[3] stays 0; next_pc[3] = miss PC; thread 3 eligible the following cycle.
5. Rollback thread 0 to 0x2000 in the same cycle as thread 0 is requesting → not granted that cycle; next fetch of thread 0 is 0x2000. Rollback plus miss on thread 0 → next_pc = rollback PC, blocked[0] = 1.
6. Thread 2 next_pc = 32'hFFFFFFFC granted twice → ift_pc FFFFFFFC then 0. Assert reset mid-run with thread 1 blocked → all outputs 0, blocked 0, PCs = RESET_PC.
